// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the pipeline's memory stage.
// Accepts one load/store at a time over valid/ready and waits WAIT_STATES
// extra cycles. It then answers with a one-cycle response pulse. Byte lanes
// are big-endian, and load data is right-justified and extended.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned
// half/word accesses and the reserved size with resp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signext,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_next;
  logic [3:0]     cnt;
  logic           wr_q, sext_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [1:0]     size_q;

  logic [31:0]    mem [DEPTH_WORDS];

  // Request fields seen by the datapath: live inputs while idle (the
  // zero-wait case enters RESP straight from IDLE), latched copy otherwise.
  logic           op_write, op_sext;
  logic [AW+1:0]  op_addr;
  logic [31:0]    op_wdata;
  logic [1:0]     op_size;
  logic [AW-1:0]  idx;
  logic           enter_resp, illegal;
  logic [3:0]     be;
  logic [31:0]    wbus, word_rd, shifted, load_val;
  logic [15:0]    half_v;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready  = (state == S_IDLE) && reset;
    resp_valid = (state == S_RESP);
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
    end else if (state == S_IDLE && req_valid) begin
      cnt     <= WAIT_LOAD;
      wr_q    <= req_write;
      sext_q  <= req_signext;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
      size_q  <= req_size;
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Operand selection and legality check.
  always_comb begin
    if (state == S_IDLE) begin
      op_write = req_write;
      op_sext  = req_signext;
      op_addr  = req_addr[AW+1:0];
      op_wdata = req_wdata;
      op_size  = req_size;
    end else begin
      op_write = wr_q;
      op_sext  = sext_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_size  = size_q;
    end
    idx        = op_addr[AW+1:2];
    enter_resp = (state_next == S_RESP);
`ifdef DMEM_ALIGN_CHECK_EN
    illegal = (op_size == 2'b11) ||
              (op_size == 2'b01 && op_addr[0]) ||
              (op_size == 2'b10 && op_addr[1:0] != 2'b00);
`else
    illegal = 1'b0;
`endif
  end

  // Big-endian lane selection for stores and load extraction/extension.
  always_comb begin
    word_rd  = mem[idx];
    shifted  = word_rd << {op_addr[1:0], 3'b000};
    half_v   = op_addr[1] ? word_rd[15:0] : word_rd[31:16];
    be       = 4'b1111;
    wbus     = op_wdata;
    load_val = word_rd;
    case (op_size)
      2'b00: begin
        be       = 4'b1000 >> op_addr[1:0];
        wbus     = {4{op_wdata[7:0]}};
        load_val = {{24{op_sext & shifted[31]}}, shifted[31:24]};
      end
      2'b01: begin
        be       = op_addr[1] ? 4'b0011 : 4'b1100;
        wbus     = {2{op_wdata[15:0]}};
        load_val = {{16{op_sext & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

  // Store commit on the edge entering RESP; only the selected lanes change.
  // NOTE: the array has no reset; contents are undefined until written, and gating on reset keeps a held-in-reset request from writing.
  always_ff @(posedge clock) begin
    if (reset && enter_resp && op_write && !illegal) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wbus[8*b +: 8];
      end
    end
  end

  // Registered response data/error, captured on entry to RESP and held after.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= illegal;
      resp_rdata <= (op_write || illegal) ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=1024, WAIT_STATES=2).
// Expected data comes from a byte-addressed big-endian reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 2;
  localparam int BYTES = 4 * DEPTH;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signext = 1'b0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [BYTES];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ready_low;
    bit          single;
    bit          held;
    bit          timeout;
  } resp_t;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signext(req_signext),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_illegal(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int p = int'(a) & (BYTES - 1);
    case (sz)
      2'b00: ref_mem[p] = d[7:0];
      2'b01: begin
        p = p & ~1;
        ref_mem[p] = d[15:8]; ref_mem[p+1] = d[7:0];
      end
      default: begin
        p = p & ~3;
        ref_mem[p] = d[31:24]; ref_mem[p+1] = d[23:16];
        ref_mem[p+2] = d[15:8]; ref_mem[p+3] = d[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic se);
    int p = int'(a) & (BYTES - 1);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'b00: begin
        b = ref_mem[p];
        return se ? {{24{b[7]}}, b} : {24'd0, b};
      end
      2'b01: begin
        p = p & ~1;
        h = {ref_mem[p], ref_mem[p+1]};
        return se ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: begin
        p = p & ~3;
        return {ref_mem[p], ref_mem[p+1], ref_mem[p+2], ref_mem[p+3]};
      end
    endcase
  endfunction

  // Runs one request to completion and reports what was observed.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic se, output resp_t r);
    int guard;
    r.rdata = 32'd0; r.err = 1'b0; r.lat = 0; r.ready_low = 0;
    r.single = 1'b0; r.held = 1'b0; r.timeout = 1'b0;
    @(negedge clock);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) begin
      r.timeout = 1'b1;
      return;
    end
    req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_signext = se;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    if (w && !is_illegal(a, sz)) model_store(a, d, sz);
    guard = 0;
    while (guard < 50) begin
      @(negedge clock);
      r.lat++;
      if (req_ready !== 1'b1) r.ready_low++;
      if (resp_valid === 1'b1) break;
      guard++;
    end
    if (resp_valid !== 1'b1) begin
      r.timeout = 1'b1;
      return;
    end
    r.rdata = resp_rdata;
    r.err   = resp_err;
    @(negedge clock);
    r.single = (resp_valid === 1'b0);
    if (req_ready !== 1'b1) r.ready_low++;
    r.held = (resp_rdata === r.rdata) && (resp_err === r.err);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b valid=%b err=%b rdata=%h, want all 0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word();
    resp_t r;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, r);
    n_checks++;
    if (r.timeout || r.lat != WS + 1 || r.ready_low != WS + 1 || !r.single || r.rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL store_word: timeout=%0b lat=%0d ready_low=%0d single=%0b rdata=%h, want lat=%0d ready_low=%0d single=1 rdata=0",
               r.timeout, r.lat, r.ready_low, r.single, r.rdata, WS + 1, WS + 1);
    end
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r);
    n_checks++;
    if (r.timeout || r.rdata !== 32'hDEADBEEF || r.lat != WS + 1 || r.ready_low != WS + 1) begin
      n_fail++;
      $display("FAIL load_word: timeout=%0b rdata=%h lat=%0d ready_low=%0d, want DEADBEEF lat=%0d ready_low=%0d",
               r.timeout, r.rdata, r.lat, r.ready_low, WS + 1, WS + 1);
    end
    n_checks++;
    if (!r.single || !r.held) begin
      n_fail++;
      $display("FAIL load_word_pulse_hold: single=%0b held=%0b want 1 1", r.single, r.held);
    end
  endtask

  task automatic test_byte();
    resp_t r;
    do_req(1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, r);
    do_req(1'b0, 32'h13, 32'd0, 2'b00, 1'b1, r);
    n_checks++;
    if (r.rdata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL load_byte_sext: got %h want FFFFFF80", r.rdata);
    end
    do_req(1'b0, 32'h13, 32'd0, 2'b00, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'h00000080) begin
      n_fail++;
      $display("FAIL load_byte_zext: got %h want 00000080", r.rdata);
    end
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'hDEADBE80) begin
      n_fail++;
      $display("FAIL load_word_after_byte: got %h want DEADBE80", r.rdata);
    end
    do_req(1'b0, 32'h10, 32'd0, 2'b00, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'h000000DE) begin
      n_fail++;
      $display("FAIL load_byte_off0: got %h want 000000DE", r.rdata);
    end
  endtask

  task automatic test_half();
    resp_t r;
    do_req(1'b0, 32'h10, 32'd0, 2'b01, 1'b1, r);
    n_checks++;
    if (r.rdata !== 32'hFFFFDEAD) begin
      n_fail++;
      $display("FAIL load_half_sext: got %h want FFFFDEAD", r.rdata);
    end
    do_req(1'b0, 32'h12, 32'd0, 2'b01, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'h0000BE80) begin
      n_fail++;
      $display("FAIL load_half_low_zext: got %h want 0000BE80", r.rdata);
    end
  endtask

  task automatic test_wrap();
    resp_t r;
    do_req(1'b1, 32'h1010, 32'h0000_0001, 2'b10, 1'b0, r);
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'h00000001) begin
      n_fail++;
      $display("FAIL addr_wrap: got %h want 00000001", r.rdata);
    end
  endtask

  task automatic test_abort();
    resp_t r;
    int seen;
    do_req(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, r);
    @(negedge clock);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'b10; req_signext = 1'b0; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_response: %0d bad cycles want 0", seen);
    end
    do_req(1'b0, 32'h20, 32'd0, 2'b10, 1'b0, r);
    n_checks++;
    if (r.rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL abort_store_dropped: got %h want CAFEF00D", r.rdata);
    end
  endtask

  task automatic test_misaligned();
    resp_t r;
    logic [31:0] exp_d;
    logic        exp_e;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_d = 32'd0; exp_e = 1'b1;
`else
    exp_d = model_load(32'h10, 2'b10, 1'b0); exp_e = 1'b0;
`endif
    do_req(1'b0, 32'h12, 32'd0, 2'b10, 1'b0, r);
    n_checks++;
    if (r.rdata !== exp_d || r.err !== exp_e || r.lat != WS + 1) begin
      n_fail++;
      $display("FAIL misaligned_load: rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
               r.rdata, r.err, r.lat, exp_d, exp_e, WS + 1);
    end
    do_req(1'b1, 32'h11, 32'hA5A55A5A, 2'b10, 1'b0, r);
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r);
    exp_d = model_load(32'h10, 2'b10, 1'b0);
    n_checks++;
    if (r.rdata !== exp_d || r.err !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_store_effect: got %h err=%b want %h err=0", r.rdata, r.err, exp_d);
    end
  endtask

  task automatic test_random();
    resp_t r;
    logic [31:0] a, d, exp_d;
    logic [1:0]  sz;
    logic        w, se;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 2'b10, 1'b0, r);
    end
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'h100 + 32'($urandom_range(0, 15) * 4) + (32'($urandom_range(0, 7)) << 12);
      if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
      if (sz == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
      w  = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      d  = $urandom;
      exp_d = w ? 32'd0 : model_load(a, sz, se);
      do_req(w, a, d, sz, se, r);
      n_checks++;
      if (r.timeout || r.rdata !== exp_d || r.err !== 1'b0 || r.lat != WS + 1) begin
        n_fail++;
        $display("FAIL random_%0d: w=%b a=%h sz=%0d se=%b got rdata=%h err=%b lat=%0d timeout=%0b want rdata=%h err=0 lat=%0d",
                 i, w, a, sz, se, r.rdata, r.err, r.lat, r.timeout, exp_d, WS + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap();
    test_abort();
    test_misaligned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
